// File: rtl/uart_pkg.sv
// Definitions shared between the TX feeder and the TX serializer side.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_BUSY = 2'b11,
        ST_WAIT_DONE = 2'b10
    } issue_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with occupancy count and a sticky overflow flag.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_acc, rd_acc;

    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign overflow = overflow_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Acceptance uses this cycle's full, so a same-cycle pop never rescues a write.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d   = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        overflow_d = overflow_q || (wr_en && full);
        count_d    = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and issues them one at a time to the UART TX, paced on tx_busy.
//   state      | meaning
//   IDLE       | wait for a queued byte and TX not busy; pop into tx_data
//   ISSUE      | tx_valid pulse, clear timeout counter
//   WAIT_BUSY  | wait for TX to raise busy, give up after BUSY_TIMEOUT cycles
//   WAIT_DONE  | wait for TX to drop busy
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     tx_busy,
    output logic                     tx_valid,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_timeout
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT);

    issue_state_e          state_q, state_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  timeout_q, timeout_d;
    logic                  pop;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        tx_data_d = tx_data_q;
        timeout_d = timeout_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_busy) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_rd_data;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                    // TX never picked the byte up; drop it and move on.
                    if (tmo_cnt_q + TMO_ONE == TMO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            tx_data_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            tx_data_q <= tx_data_d;
            timeout_q <= timeout_d;
        end
    end

    assign tx_valid   = (state_q == ST_ISSUE);
    assign tx_data    = tx_data_q;
    assign tx_timeout = timeout_q;

endmodule
